// File: rtl/cbus_arbiter.sv
// cbus_arbiter: shares one memory bus between the instruction cache (I) and the
// data cache (D). A grant holds until the burst ends; outputs are forwarded
// combinationally from the owner while BUSY and forced to zero while IDLE.
//
// Optional feature: define CBUS_ARB_RR_EN for round-robin arbitration on
// simultaneous requests; without it D always wins contention.
//
// Flat bus layout (MSB first):
//   req  [150] valid, [149] is_write, [148:146] size, [145:82] addr,
//        [81:74] strobe, [73:10] data, [9:2] len, [1:0] burst
//   resp [65] ready, [64] last, [63:0] data
module cbus_arbiter (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [150:0] ireq_i,
    output logic [65:0]  iresp_o,
    input  logic [150:0] dreq_i,
    output logic [65:0]  dresp_o,
    output logic [150:0] oreq_o,
    input  logic [65:0]  oresp_i
);

    localparam int unsigned ReqValidBit  = 150;
    localparam int unsigned ReqLenMsb    = 9;
    localparam int unsigned ReqLenLsb    = 2;
    localparam int unsigned RespReadyBit = 65;
    localparam int unsigned RespLastBit  = 64;

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

    state_e      state_q;
    logic        owner_q;   // 0 = I, 1 = D
    logic [8:0]  beat_q;
    logic [7:0]  len_q;

    logic        i_valid;
    logic        d_valid;
    logic        contend_pick;
    logic        grant_sel;
    logic [8:0]  beat_inc;
    logic        burst_end;

    assign i_valid = ireq_i[ReqValidBit];
    assign d_valid = dreq_i[ReqValidBit];

`ifdef CBUS_ARB_RR_EN
    logic rr_q;             // requester favoured on the next contention (1 = D)
    assign contend_pick = rr_q;
`else
    assign contend_pick = 1'b1;
`endif

    // Winner selection in IDLE: a lone requester wins outright.
    always_comb begin
        grant_sel = d_valid;
        if (i_valid && d_valid) begin
            grant_sel = contend_pick;
        end
    end

    // Burst ends on ready+last, or after len+1 ready beats if last never comes.
    assign beat_inc  = beat_q + 9'd1;
    assign burst_end = oresp_i[RespReadyBit] &&
                       (oresp_i[RespLastBit] || (beat_inc == ({1'b0, len_q} + 9'd1)));

    // FSM, owner, beat counter and latched burst length.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            beat_q  <= 9'd0;
            len_q   <= 8'd0;
`ifdef CBUS_ARB_RR_EN
            rr_q    <= 1'b1;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_valid || d_valid) begin
                        state_q <= StBusy;
                        owner_q <= grant_sel;
                        beat_q  <= 9'd0;
                        len_q   <= grant_sel ? dreq_i[ReqLenMsb:ReqLenLsb]
                                             : ireq_i[ReqLenMsb:ReqLenLsb];
`ifdef CBUS_ARB_RR_EN
                        rr_q    <= ~grant_sel;
`endif
                    end
                end
                StBusy: begin
                    if (oresp_i[RespReadyBit]) begin
                        beat_q <= beat_inc;
                        if (burst_end) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Combinational forwarding between the owner and the shared bus.
    always_comb begin
        oreq_o  = '0;
        iresp_o = '0;
        dresp_o = '0;
        if (state_q == StBusy) begin
            if (owner_q) begin
                oreq_o  = dreq_i;
                dresp_o = oresp_i;
            end else begin
                oreq_o  = ireq_i;
                iresp_o = oresp_i;
            end
        end
    end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter; expectations track CBUS_ARB_RR_EN.
module tb_cbus_arbiter;

    logic         clk;
    logic         reset;
    logic [150:0] ireq;
    logic [150:0] dreq;
    logic [150:0] oreq;
    logic [65:0]  iresp;
    logic [65:0]  dresp;
    logic [65:0]  oresp;

    int total;
    int passed;

    cbus_arbiter dut (
        .clk_i   (clk),
        .reset_i (reset),
        .ireq_i  (ireq),
        .iresp_o (iresp),
        .dreq_i  (dreq),
        .dresp_o (dresp),
        .oreq_o  (oreq),
        .oresp_i (oresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    function automatic logic [150:0] mk_req(input logic v, input logic [63:0] a,
                                            input logic [7:0] l, input logic [63:0] d);
        logic [150:0] r;
        r          = '0;
        r[150]     = v;
        r[148:146] = 3'd3;
        r[145:82]  = a;
        r[73:10]   = d;
        r[9:2]     = l;
        r[1:0]     = 2'b01;
        return r;
    endfunction

    function automatic logic [65:0] mk_resp(input logic rdy, input logic last,
                                            input logic [63:0] d);
        return {rdy, last, d};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset;
        reset = 1'b1;
        #2;
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset;
        logic [150:0] ri;
        ri    = mk_req(1'b1, 64'h8000_0000, 8'd15, 64'h0);
        reset = 1'b1;
        ireq  = '0;
        dreq  = '0;
        oresp = '0;
        #3;
        total++; if (oreq !== '0) $display("FAIL rst_oreq: got %h expected 0", oreq); else passed++;
        total++; if (iresp !== '0) $display("FAIL rst_iresp: got %h expected 0", iresp); else passed++;
        total++; if (dresp !== '0) $display("FAIL rst_dresp: got %h expected 0", dresp); else passed++;
        ireq  = ri;
        oresp = mk_resp(1'b1, 1'b0, 64'h5);
        step();
        step();
        total++; if (oreq !== '0) $display("FAIL rst_hold: got %h expected 0", oreq); else passed++;
        total++; if (iresp !== '0) $display("FAIL rst_hold_iresp: got %h expected 0", iresp); else passed++;
        ireq  = '0;
        oresp = '0;
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_i;
        logic [150:0] ri;
        ri    = mk_req(1'b1, 64'h8000_0000, 8'd15, 64'h0);
        ireq  = ri;
        oresp = mk_resp(1'b1, 1'b1, 64'hDEAD);
        #1;
        total++; if (oreq !== '0) $display("FAIL single_idle_oreq: got %h expected 0", oreq); else passed++;
        total++; if (iresp !== '0) $display("FAIL single_idle_ready: got %h expected 0", iresp); else passed++;
        step();
        total++; if (oreq !== ri) $display("FAIL single_grant: got %h expected %h", oreq, ri); else passed++;
        for (int b = 0; b < 16; b++) begin
            oresp = mk_resp(1'b1, b == 15, 64'hA0 + 64'(b));
            #1;
            total++; if (iresp !== oresp) $display("FAIL single_iresp b%0d: got %h expected %h", b, iresp, oresp); else passed++;
            total++; if (dresp !== '0) $display("FAIL single_dresp b%0d: got %h expected 0", b, dresp); else passed++;
            total++; if (oreq !== ri) $display("FAIL single_oreq b%0d: got %h expected %h", b, oreq, ri); else passed++;
            step();
        end
        oresp = '0;
        #1;
        total++; if (oreq !== '0) $display("FAIL single_back_idle: got %h expected 0", oreq); else passed++;
        ireq = '0;
        step();
    endtask

    task automatic test_contention;
        logic [150:0] ri;
        logic [150:0] rd;
        logic         exp_d;
        pulse_reset();
        ri   = mk_req(1'b1, 64'h1000, 8'd0, 64'h11);
        rd   = mk_req(1'b1, 64'h2000, 8'd0, 64'h22);
        ireq = ri;
        dreq = rd;
        for (int k = 0; k < 4; k++) begin
            step();
`ifdef CBUS_ARB_RR_EN
            exp_d = (k % 2) == 0;
`else
            exp_d = 1'b1;
`endif
            total++; if (oreq !== (exp_d ? rd : ri)) $display("FAIL contend_grant k%0d: got %h expected %h", k, oreq, exp_d ? rd : ri); else passed++;
            oresp = mk_resp(1'b1, 1'b1, 64'(k));
            #1;
            total++;
            if ({iresp, dresp} !== (exp_d ? {66'd0, oresp} : {oresp, 66'd0}))
                $display("FAIL contend_resp k%0d: got %h expected %h", k, {iresp, dresp},
                         exp_d ? {66'd0, oresp} : {oresp, 66'd0});
            else passed++;
            step();
            oresp = '0;
            #1;
            total++; if (oreq !== '0) $display("FAIL contend_bubble k%0d: got %h expected 0", k, oreq); else passed++;
        end
        dreq = '0;
        step();
        total++; if (oreq !== ri) $display("FAIL contend_i_after: got %h expected %h", oreq, ri); else passed++;
        oresp = mk_resp(1'b1, 1'b1, 64'h7);
        step();
        oresp = '0;
        ireq  = '0;
        step();
    endtask

    task automatic test_late_requester;
        logic [150:0] ri;
        logic [150:0] rd;
        ri   = mk_req(1'b1, 64'h8000_0000, 8'd15, 64'h0);
        rd   = mk_req(1'b1, 64'h9000, 8'd0, 64'h33);
        ireq = ri;
        dreq = '0;
        step();
        for (int b = 0; b < 16; b++) begin
            if (b == 2) dreq = rd;
            oresp = mk_resp(1'b1, b == 15, 64'(b));
            #1;
            total++; if (dresp !== '0) $display("FAIL late_dresp b%0d: got %h expected 0", b, dresp); else passed++;
            total++; if (oreq !== ri) $display("FAIL late_oreq b%0d: got %h expected %h", b, oreq, ri); else passed++;
            step();
        end
        oresp = '0;
        #1;
        total++; if (oreq !== '0) $display("FAIL late_bubble: got %h expected 0", oreq); else passed++;
        ireq = '0;
        step();
        total++; if (oreq !== rd) $display("FAIL late_grant: got %h expected %h", oreq, rd); else passed++;
        oresp = mk_resp(1'b1, 1'b1, 64'h5);
        #1;
        total++; if (dresp !== oresp) $display("FAIL late_dresp_fwd: got %h expected %h", dresp, oresp); else passed++;
        step();
        oresp = '0;
        dreq  = '0;
        step();
    endtask

    task automatic test_reset_mid_burst;
        logic [150:0] ri;
        ri   = mk_req(1'b1, 64'h8000_0040, 8'd15, 64'h0);
        ireq = ri;
        step();
        for (int b = 0; b < 5; b++) begin
            oresp = mk_resp(1'b1, 1'b0, 64'(b));
            step();
        end
        oresp = mk_resp(1'b1, 1'b0, 64'h5);
        #1;
        total++; if (iresp !== oresp) $display("FAIL rstmid_pre: got %h expected %h", iresp, oresp); else passed++;
        #1;
        reset = 1'b1;
        #1;
        total++; if (oreq !== '0) $display("FAIL rstmid_oreq: got %h expected 0", oreq); else passed++;
        total++; if (iresp !== '0) $display("FAIL rstmid_iresp: got %h expected 0", iresp); else passed++;
        total++; if (dresp !== '0) $display("FAIL rstmid_dresp: got %h expected 0", dresp); else passed++;
        oresp = '0;
        @(negedge clk);
        reset = 1'b0;
        step();
        total++; if (oreq !== ri) $display("FAIL rstmid_regrant: got %h expected %h", oreq, ri); else passed++;
        oresp = mk_resp(1'b1, 1'b1, 64'h0);
        step();
        oresp = '0;
        ireq  = '0;
        step();
    endtask

    task automatic test_missing_last;
        logic [150:0] ri;
        ri   = mk_req(1'b1, 64'h4000, 8'd3, 64'h0);
        ireq = ri;
        step();
        for (int b = 0; b < 4; b++) begin
            oresp = mk_resp(1'b1, 1'b0, 64'(b));
            #1;
            total++; if (oreq !== ri) $display("FAIL miss_busy b%0d: got %h expected %h", b, oreq, ri); else passed++;
            total++; if (iresp !== oresp) $display("FAIL miss_iresp b%0d: got %h expected %h", b, iresp, oresp); else passed++;
            step();
        end
        oresp = '0;
        #1;
        total++; if (oreq !== '0) $display("FAIL miss_idle: got %h expected 0", oreq); else passed++;
        ireq = '0;
        step();
    endtask

    task automatic test_owner_drop;
        logic [150:0] ri;
        logic [150:0] ri_nv;
        logic [150:0] rd;
        ri    = mk_req(1'b1, 64'h8000_0100, 8'd15, 64'h0);
        ri_nv = mk_req(1'b0, 64'h8000_0100, 8'd15, 64'h0);
        rd    = mk_req(1'b1, 64'hA000, 8'd0, 64'h44);
        ireq  = ri;
        dreq  = '0;
        step();
        dreq = rd;
        for (int b = 0; b < 16; b++) begin
            ireq  = (b == 3 || b == 4) ? ri_nv : ri;
            oresp = mk_resp(1'b1, b == 15, 64'(b));
            #1;
            total++; if (oreq !== ireq) $display("FAIL drop_oreq b%0d: got %h expected %h", b, oreq, ireq); else passed++;
            total++; if (oreq[150] !== ireq[150]) $display("FAIL drop_valid b%0d: got %b expected %b", b, oreq[150], ireq[150]); else passed++;
            total++; if (dresp !== '0) $display("FAIL drop_dresp b%0d: got %h expected 0", b, dresp); else passed++;
            step();
        end
        oresp = '0;
        #1;
        total++; if (oreq !== '0) $display("FAIL drop_idle: got %h expected 0", oreq); else passed++;
        ireq = '0;
        step();
        total++; if (oreq !== rd) $display("FAIL drop_d_grant: got %h expected %h", oreq, rd); else passed++;
        oresp = mk_resp(1'b1, 1'b1, 64'h9);
        step();
        oresp = '0;
        dreq  = '0;
        step();
    endtask

    initial begin
        total  = 0;
        passed = 0;
        test_reset();
        test_single_i();
        test_contention();
        test_late_requester();
        test_reset_mid_burst();
        test_missing_last();
        test_owner_drop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cbus_arbiter.md
CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 The block SHALL have no parameters; bus widths are fixed by the common package (cbus_req_t 151 bits, cbus_resp_t 66 bits).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ireq  input  151  cbus_req_t from the instruction cache.
REQ-005 iresp  output  66  cbus_resp_t to the instruction cache.
REQ-006 dreq  input  151  cbus_req_t from the data cache.
REQ-007 dresp  output  66  cbus_resp_t to the data cache.
REQ-008 oreq  output  151  cbus_req_t to the shared memory bus.
REQ-009 oresp  input  66  cbus_resp_t from the shared memory bus.

Function
REQ-010 The block SHALL implement a two-state FSM, IDLE and BUSY, plus a 1-bit owner register (0 = I, 1 = D).
REQ-011 In IDLE, oreq SHALL be all zeros, and iresp and dresp SHALL be all zeros.
REQ-012 In IDLE, if exactly one of ireq.valid and dreq.valid is 1, that requester SHALL be latched as owner, and the FSM SHALL enter BUSY on the next edge.
REQ-013 In IDLE, if ireq.valid and dreq.valid are both 1, the winner SHALL be chosen by the priority rule in REQ-025/REQ-026.
REQ-014 In BUSY, oreq SHALL equal the owner's request, combinationally and unmodified.
REQ-015 In BUSY, the owner's response port SHALL equal oresp, and the non-owner's response port SHALL be all zeros.
REQ-016 In BUSY, the owner SHALL not change until a beat with oresp.ready=1 and oresp.last=1 is seen; the FSM SHALL then return to IDLE on that edge.
REQ-017 Grant latency SHALL be one cycle from request valid in IDLE to oreq.valid=1.
REQ-018 Exactly one idle bubble cycle SHALL separate back-to-back transactions.
REQ-019 A 9-bit beat counter SHALL clear on entry to BUSY and increment on each oresp.ready=1 beat.
REQ-020 If the beat counter reaches the latched len+1 without oresp.last, the block SHALL still return to IDLE after that beat (protocol-error recovery).
REQ-021 A non-owner's valid SHALL be ignored and held off during BUSY; the non-owner receives no ready until it is granted.
REQ-022 Loss of the owner's valid during BUSY SHALL NOT release the grant; oreq.valid follows the owner's valid.
REQ-023 oresp.ready while in IDLE SHALL be ignored.

Reset
REQ-024 While reset=1, independent of clk, the block SHALL force: FSM=IDLE, owner=0, beat counter=0, the round-robin pointer (if present) pointing at D; oreq, iresp and dresp SHALL read all zeros. A reset asserted mid-burst SHALL abort the burst with no further forwarding.

Configuration
REQ-025 With CBUS_ARB_RR_EN defined, simultaneous requests in IDLE SHALL be granted round-robin: the pointer flips to the other requester after each grant, and the first contention after reset grants D.
REQ-026 Without CBUS_ARB_RR_EN, simultaneous requests SHALL always grant D (fixed data priority), and no pointer flop SHALL exist.

Verification
REQ-027 Single I request: ireq valid, len=MLEN16, addr 0x8000_0000 → oreq equals ireq from cycle 1; iresp.ready mirrors 16 beats; IDLE after last; dresp stays zero throughout.
REQ-028 Contention: ireq and dreq asserted on the same cycle, repeated 4 transactions → RR build grants D,I,D,I; fixed build grants D,D,D,D, with I starved until dreq drops.
REQ-029 Late requester: dreq asserted while I owns a 16-beat burst → dresp stays zero; D is granted in the cycle after I's last beat plus one bubble.
REQ-030 Reset mid-burst: reset at beat 5 of 16 → oreq, iresp and dresp all zero asynchronously; after release, a new ireq is granted in 1 cycle.
REQ-031 Missing last: len=MLEN4 with oresp.last never asserted → FSM returns to IDLE after the 4th ready beat.
REQ-032 Owner drops valid mid-burst: ireq.valid low for 2 cycles → oreq.valid low for those cycles, owner still I, and no D grant occurs.
